// File: rtl/pc_gen_if.sv
// Program-counter control bundle: redirect/exception requests in, pc/epc/status out.
// The master drives requests; the pc_gen slave returns registered pc state.
interface pc_gen_if #(
   parameter int WIDTH = 32
);
   logic             stall;
   logic             redir_valid;
   logic [WIDTH-1:0] redir_target;
   logic             exc;
   logic             eret;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] epc;
   logic             in_handler;
   logic             redir_pending;
   logic             exc_taken;
   logic             addr_err;

   modport master (
      output stall, redir_valid, redir_target, exc, eret,
      input  pc, epc, in_handler, redir_pending, exc_taken, addr_err
   );

   modport slave (
      input  stall, redir_valid, redir_target, exc, eret,
      output pc, epc, in_handler, redir_pending, exc_taken, addr_err
   );
endinterface

// File: rtl/pc_gen.sv
// Program counter generator with RUN/HANDLER exception FSM and one-deep redirect buffer; all outputs registered.
// Optional PC_GEN_ALIGN_CHECK_EN turns misaligned redirect targets into exceptions (else bits [1:0] are cleared).
module pc_gen #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_ADDR = '0,
   parameter logic [WIDTH-1:0] EXC_ADDR   = WIDTH'(32'h00000800),
   parameter int               STEP       = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   pc_gen_if.slave  bus
);

   typedef enum logic {RUN, HANDLER} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
   logic             pend_q, pend_d;
   logic             exc_taken_q, exc_taken_d;
   logic [WIDTH-1:0] redir_tgt;
   logic             bad_redir;
   logic             eret_ok;

   assign eret_ok = bus.eret && (state_q == HANDLER);

`ifdef PC_GEN_ALIGN_CHECK_EN
   logic take_direct;
   logic take_pend;
   logic addr_err_q;

   // Raw target is kept so misalignment can be judged when the redirect is consumed.
   assign redir_tgt   = bus.redir_target;
   assign take_direct = bus.redir_valid && !bus.stall;
   assign take_pend   = !bus.redir_valid && pend_q && !bus.stall;
   assign bad_redir   = (take_direct && (bus.redir_target[1:0] != 2'b00)) ||
                        (take_pend   && (pend_tgt_q[1:0]       != 2'b00));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_err_q <= 1'b0;
      end else begin
         addr_err_q <= bad_redir && !eret_ok && !bus.exc;
      end
   end

   assign bus.addr_err = addr_err_q;
`else
   assign redir_tgt    = {bus.redir_target[WIDTH-1:2], 2'b00};
   assign bad_redir    = 1'b0;
   assign bus.addr_err = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      epc_d       = epc_q;
      pend_d      = pend_q;
      pend_tgt_d  = pend_tgt_q;
      exc_taken_d = 1'b0;

      // A misaligned redirect only wins if nothing above it in priority fires.
      if (bus.exc || (bad_redir && !eret_ok)) begin
         pc_d        = EXC_ADDR;
         if (state_q == RUN) begin
            epc_d = pc_q;
         end
         state_d     = HANDLER;
         pend_d      = 1'b0;
         exc_taken_d = 1'b1;
      end else if (eret_ok) begin
         pc_d    = epc_q;
         state_d = RUN;
         pend_d  = 1'b0;
      end else if (bus.redir_valid) begin
         if (bus.stall) begin
            pend_d     = 1'b1;
            pend_tgt_d = redir_tgt;
         end else begin
            pc_d   = redir_tgt;
            pend_d = 1'b0;
         end
      end else if (pend_q && !bus.stall) begin
         pc_d   = pend_tgt_q;
         pend_d = 1'b0;
      end else if (!bus.stall) begin
         pc_d = pc_q + WIDTH'(STEP);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         pc_q        <= RESET_ADDR;
         epc_q       <= '0;
         pend_q      <= 1'b0;
         pend_tgt_q  <= '0;
         exc_taken_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         epc_q       <= epc_d;
         pend_q      <= pend_d;
         pend_tgt_q  <= pend_tgt_d;
         exc_taken_q <= exc_taken_d;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.epc           = epc_q;
   assign bus.in_handler    = (state_q == HANDLER);
   assign bus.redir_pending = pend_q;
   assign bus.exc_taken     = exc_taken_q;

endmodule

// File: tb/tb_pc_gen.sv
// Randomized self-checking bench for pc_gen against a behavioural model; covers both PC_GEN_ALIGN_CHECK_EN builds.
module tb_pc_gen;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pc_gen_if #(.WIDTH(32)) bus ();
   pc_gen_if #(.WIDTH(8))  bus8 ();

   pc_gen #(.WIDTH(32), .RESET_ADDR(32'h0), .EXC_ADDR(32'h800), .STEP(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   pc_gen #(.WIDTH(8), .RESET_ADDR(8'hFC), .EXC_ADDR(8'h80), .STEP(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(bus8)
   );

   int vecs;
   int errs;

   logic [31:0] m_pc, m_epc, m_ptgt;
   bit          m_hand, m_pend, m_exct, m_aerr;

   task automatic model_reset();
      m_pc = 32'h0; m_epc = 32'h0; m_ptgt = 32'h0;
      m_hand = 0; m_pend = 0; m_exct = 0; m_aerr = 0;
   endtask

   // Spec-level next-state: which event wins this cycle, and what it does.
   task automatic model_step(bit st, bit rv, logic [31:0] rt, bit ex, bit er);
      logic [31:0] t, ctgt;
      bit consume, misal, eret_acc;
`ifdef PC_GEN_ALIGN_CHECK_EN
      t = rt;
`else
      t = rt & ~32'h3;
`endif
      m_exct   = 0;
      m_aerr   = 0;
      eret_acc = er && m_hand;
      consume  = !st && (rv || m_pend);
      ctgt     = rv ? t : m_ptgt;
      misal    = consume && (ctgt[1:0] != 2'b00);
      if (ex || (misal && !eret_acc)) begin
         if (!m_hand) m_epc = m_pc;
         m_pc = 32'h800; m_hand = 1; m_pend = 0; m_exct = 1; m_aerr = !ex;
      end else if (eret_acc) begin
         m_pc = m_epc; m_hand = 0; m_pend = 0;
      end else if (rv && st) begin
         m_pend = 1; m_ptgt = t;
      end else if (consume) begin
         m_pc = ctgt; m_pend = 0;
      end else if (!st) begin
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic cycle(bit st, bit rv, logic [31:0] rt, bit ex, bit er);
      bus.stall = st; bus.redir_valid = rv; bus.redir_target = rt;
      bus.exc = ex; bus.eret = er;
      model_step(st, rv, rt, ex, er);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vecs++;
      if ({bus.pc, bus.epc, bus.in_handler, bus.redir_pending, bus.exc_taken, bus.addr_err} !== {32'h0, 32'h0, 4'b0000}) begin
         errs++;
         $display("FAIL reset_state: got pc=%h epc=%h h=%b p=%b et=%b ae=%b expected all zero",
                  bus.pc, bus.epc, bus.in_handler, bus.redir_pending, bus.exc_taken, bus.addr_err);
      end
      vecs++;
      if (bus8.pc !== 8'hFC) begin
         errs++;
         $display("FAIL reset_pc8: got %h expected fc", bus8.pc);
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_sequence();
      logic [7:0] e8;
      for (int i = 0; i < 5; i++) begin
         e8 = 8'hFC + 8'(4 * i);
         vecs++;
         if (bus.pc !== 32'(4 * i)) begin
            errs++;
            $display("FAIL seq_pc[%0d]: got %h expected %h", i, bus.pc, 32'(4 * i));
         end
         vecs++;
         if (bus8.pc !== e8) begin
            errs++;
            $display("FAIL wrap_pc8[%0d]: got %h expected %h", i, bus8.pc, e8);
         end
         if (i < 4) cycle(0, 0, 32'h0, 0, 0);
      end
   endtask

   task automatic test_exception();
      cycle(0, 1, 32'h100, 0, 0);
      vecs++;
      if (bus.pc !== 32'h100) begin errs++; $display("FAIL exc_setup_pc: got %h expected 100", bus.pc); end
      cycle(0, 0, 32'h0, 1, 0);
      vecs++;
      if ({bus.pc, bus.epc, bus.in_handler, bus.exc_taken} !== {32'h800, 32'h100, 2'b11}) begin
         errs++;
         $display("FAIL exc_enter: got pc=%h epc=%h h=%b et=%b expected 800 100 1 1",
                  bus.pc, bus.epc, bus.in_handler, bus.exc_taken);
      end
      cycle(0, 0, 32'h0, 0, 0);
      vecs++;
      if ({bus.pc, bus.exc_taken} !== {32'h804, 1'b0}) begin
         errs++; $display("FAIL exc_pulse_end: got pc=%h et=%b expected 804 0", bus.pc, bus.exc_taken);
      end
      cycle(0, 0, 32'h0, 1, 0);
      vecs++;
      if ({bus.pc, bus.epc, bus.in_handler, bus.exc_taken} !== {32'h800, 32'h100, 2'b11}) begin
         errs++;
         $display("FAIL exc_nested: got pc=%h epc=%h h=%b et=%b expected 800 100 1 1",
                  bus.pc, bus.epc, bus.in_handler, bus.exc_taken);
      end
      cycle(0, 0, 32'h0, 0, 1);
      vecs++;
      if ({bus.pc, bus.in_handler, bus.exc_taken} !== {32'h100, 2'b00}) begin
         errs++; $display("FAIL eret: got pc=%h h=%b et=%b expected 100 0 0", bus.pc, bus.in_handler, bus.exc_taken);
      end
   endtask

   task automatic test_stall_buffer();
      cycle(1, 1, 32'h200, 0, 0);
      cycle(1, 1, 32'h300, 0, 0);
      vecs++;
      if ({bus.pc, bus.redir_pending} !== {32'h100, 1'b1}) begin
         errs++; $display("FAIL stall_hold: got pc=%h p=%b expected 100 1", bus.pc, bus.redir_pending);
      end
      cycle(1, 0, 32'h0, 0, 0);
      vecs++;
      if ({bus.pc, bus.redir_pending} !== {32'h100, 1'b1}) begin
         errs++; $display("FAIL stall_keep: got pc=%h p=%b expected 100 1", bus.pc, bus.redir_pending);
      end
      cycle(0, 0, 32'h0, 0, 0);
      vecs++;
      if ({bus.pc, bus.redir_pending} !== {32'h300, 1'b0}) begin
         errs++; $display("FAIL stall_release: got pc=%h p=%b expected 300 0", bus.pc, bus.redir_pending);
      end
   endtask

   task automatic test_priority();
      cycle(1, 1, 32'h40, 0, 0);
      cycle(1, 1, 32'h40, 1, 1);
      vecs++;
      if ({bus.pc, bus.epc, bus.redir_pending, bus.in_handler} !== {32'h800, 32'h300, 2'b01}) begin
         errs++;
         $display("FAIL prio_exc: got pc=%h epc=%h p=%b h=%b expected 800 300 0 1",
                  bus.pc, bus.epc, bus.redir_pending, bus.in_handler);
      end
      cycle(1, 0, 32'h0, 0, 1);
      vecs++;
      if ({bus.pc, bus.in_handler} !== {32'h300, 1'b0}) begin
         errs++; $display("FAIL prio_eret_stall: got pc=%h h=%b expected 300 0", bus.pc, bus.in_handler);
      end
      cycle(0, 0, 32'h0, 0, 1);
      vecs++;
      if (bus.pc !== 32'h304) begin
         errs++; $display("FAIL eret_in_run_ignored: got pc=%h expected 304", bus.pc);
      end
   endtask

   task automatic test_misalign();
      logic [31:0] e_pc;
      bit e_ae;
      cycle(0, 1, 32'h100, 0, 0);
      cycle(0, 1, 32'h102, 0, 0);
`ifdef PC_GEN_ALIGN_CHECK_EN
      e_pc = 32'h800; e_ae = 1;
`else
      e_pc = 32'h100; e_ae = 0;
`endif
      vecs++;
      if ({bus.pc, bus.addr_err, bus.exc_taken} !== {e_pc, e_ae, e_ae}) begin
         errs++;
         $display("FAIL misalign_direct: got pc=%h ae=%b et=%b expected %h %b %b",
                  bus.pc, bus.addr_err, bus.exc_taken, e_pc, e_ae, e_ae);
      end
      cycle(0, 0, 32'h0, 0, 1);
      vecs++;
      if ({bus.pc, bus.addr_err, bus.in_handler} !== {32'h100 + (e_ae ? 32'h0 : 32'h4), 2'b00}) begin
         errs++; $display("FAIL misalign_recover: got pc=%h ae=%b h=%b", bus.pc, bus.addr_err, bus.in_handler);
      end
      cycle(1, 1, 32'h207, 0, 0);
      cycle(0, 0, 32'h0, 0, 0);
`ifdef PC_GEN_ALIGN_CHECK_EN
      e_pc = 32'h800;
`else
      e_pc = 32'h204;
`endif
      vecs++;
      if ({bus.pc, bus.addr_err, bus.redir_pending} !== {e_pc, e_ae, 1'b0}) begin
         errs++;
         $display("FAIL misalign_pending: got pc=%h ae=%b p=%b expected %h %b 0",
                  bus.pc, bus.addr_err, bus.redir_pending, e_pc, e_ae);
      end
      cycle(0, 0, 32'h0, 0, 1);
   endtask

   task automatic test_reset_midop();
      cycle(0, 1, 32'h500, 0, 0);
      cycle(1, 1, 32'h600, 1, 0);
      #3;
      rst_n = 1'b0;
      #1;
      vecs++;
      if ({bus.pc, bus.epc, bus.in_handler, bus.redir_pending, bus.exc_taken, bus.addr_err} !== {32'h0, 32'h0, 4'b0000}) begin
         errs++;
         $display("FAIL async_reset: got pc=%h epc=%h h=%b p=%b et=%b expected zeros",
                  bus.pc, bus.epc, bus.in_handler, bus.redir_pending, bus.exc_taken);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      #2;
      vecs++;
      if (bus.pc !== 32'h0) begin errs++; $display("FAIL reset_release_hold: got %h expected 0", bus.pc); end
      #1;
      cycle(0, 0, 32'h0, 0, 0);
      vecs++;
      if (bus.pc !== 32'h4) begin errs++; $display("FAIL reset_first_step: got %h expected 4", bus.pc); end
   endtask

   task automatic test_random();
      bit st, rv, ex, er;
      logic [31:0] rt;
      for (int i = 0; i < 400; i++) begin
         st = ($urandom_range(0, 99) < 30);
         rv = ($urandom_range(0, 99) < 25);
         ex = ($urandom_range(0, 99) < 5);
         er = ($urandom_range(0, 99) < 12);
         rt = $urandom;
         cycle(st, rv, rt, ex, er);
         vecs++;
         if ({bus.pc, bus.epc, bus.in_handler, bus.redir_pending, bus.exc_taken, bus.addr_err} !==
             {m_pc, m_epc, m_hand, m_pend, m_exct, m_aerr}) begin
            errs++;
            $display("FAIL random[%0d]: got pc=%h epc=%h h=%b p=%b et=%b ae=%b expected pc=%h epc=%h h=%b p=%b et=%b ae=%b",
                     i, bus.pc, bus.epc, bus.in_handler, bus.redir_pending, bus.exc_taken, bus.addr_err,
                     m_pc, m_epc, m_hand, m_pend, m_exct, m_aerr);
         end
      end
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      model_reset();
      bus.stall = 0; bus.redir_valid = 0; bus.redir_target = '0; bus.exc = 0; bus.eret = 0;
      bus8.stall = 0; bus8.redir_valid = 0; bus8.redir_target = '0; bus8.exc = 0; bus8.eret = 0;
      test_reset();
      test_sequence();
      test_exception();
      test_stall_buffer();
      test_priority();
      test_misalign();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, default 32: bit width of every address port and register.
REQ-002 Parameter RESET_ADDR, default 32'h00000000: value loaded into pc on reset.
REQ-003 Parameter EXC_ADDR, default 32'h00000800: exception vector address.
REQ-004 Parameter STEP, default 4: sequential increment.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  hold pc; a redirect received during stall is buffered.
REQ-008 redir_valid  in  1  branch/jump redirect request.
REQ-009 redir_target  in  WIDTH  redirect address.
REQ-010 exc  in  1  exception request.
REQ-011 eret  in  1  return-from-exception request.
REQ-012 pc  out  WIDTH  current program counter, registered.
REQ-013 epc  out  WIDTH  saved exception PC, registered.
REQ-014 in_handler  out  1  state is HANDLER.
REQ-015 redir_pending  out  1  buffered redirect valid.
REQ-016 exc_taken  out  1  registered one-cycle pulse following an accepted exception.
REQ-017 addr_err  out  1  registered one-cycle pulse following a misaligned redirect; tied 0 when the macro is absent.

Function
REQ-018 Two states, RUN and HANDLER: exc moves RUN->HANDLER, eret in HANDLER moves HANDLER->RUN, and the block holds state otherwise.
REQ-019 Next-pc priority SHALL be exc, then eret (HANDLER only), then redir_valid, then pending redirect with stall low, then stall hold, then pc+STEP.
REQ-020 exc SHALL load pc with EXC_ADDR regardless of stall.
REQ-021 exc in RUN SHALL capture the current pc into epc; exc in HANDLER SHALL leave epc unchanged (nested exception).
REQ-022 eret in HANDLER without exc SHALL load pc with epc regardless of stall; eret in RUN SHALL be ignored.
REQ-023 redir_valid with stall low SHALL load pc with redir_target on the next edge and clear any pending redirect.
REQ-024 redir_valid with stall high SHALL hold pc and latch redir_target into the pending register, overwriting any older pending target.
REQ-025 Pending valid with stall low and no higher-priority event SHALL load pc with the pending target and clear the pending register.
REQ-026 exc or accepted eret SHALL clear the pending redirect.
REQ-027 pc+STEP SHALL wrap modulo 2^WIDTH with no overflow indication.
REQ-028 exc_taken SHALL assert exactly one cycle after each accepted exc, including nested exceptions.

Reset
REQ-029 While rst_n is low, pc SHALL equal RESET_ADDR, epc SHALL be 0, state SHALL be RUN, pending SHALL be clear, and exc_taken and addr_err SHALL be 0, asynchronously.
REQ-030 Deassertion of rst_n mid-operation SHALL resume from the reset values, with the first update on the following rising edge.

Configuration
REQ-031 With PC_GEN_ALIGN_CHECK_EN defined, a redirect (direct or pending) whose target has non-zero bits [1:0] SHALL be treated as exc: pc<=EXC_ADDR, epc rules per REQ-021, and addr_err pulses alongside exc_taken.
REQ-032 Without PC_GEN_ALIGN_CHECK_EN, bits [1:0] of every redirect target SHALL be forced to 0 and addr_err SHALL be constant 0.

Verification
REQ-033 Reset release, 4 idle cycles -> pc sequence 0x0, 0x4, 0x8, 0xC, 0x10.
REQ-034 pc=0x100, exc 1 cycle -> pc=0x800, epc=0x100, in_handler=1, exc_taken pulse; second exc at pc=0x804 -> epc stays 0x100; eret -> pc=0x100, in_handler=0.
REQ-035 stall=1, redir 0x200 then redir 0x300 -> pc held, redir_pending=1; stall=0 -> pc=0x300, pending cleared.
REQ-036 Same cycle exc=1, eret=1, redir_valid=1 to 0x40 while stall=1 -> pc=0x800, pending cleared.
REQ-037 WIDTH=8, RESET_ADDR=8'hFC -> pc sequence 0xFC then 0x00.
REQ-038 With macro, redir to 0x102 -> pc=0x800, addr_err and exc_taken pulse; without macro -> pc=0x100.
